trigger_formatter_axil_regs: RTL

- Parametrised AXI4-Lite slave register bank for the trigger formatter; successor to the fixed 4×32-bit scratch-register slave.
- Adds a configurable count of read/write control registers and read-only status registers, byte strobes, SLVERR decode, and per-register write-strobe pulses to the fabric.
- Sits between the PS/BFM AXI4-Lite master and the trigger formatter datapath.

---
 rtl/trigger_formatter_axil_regs.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/trigger_formatter_axil_regs.sv
// AXI4-Lite register bank for the trigger formatter: R/W control registers, read-only status
// registers, byte strobes, SLVERR decode and per-register write pulses. Optional macro: TRIG_FMT_REGS_LOCK_EN.
module trigger_formatter_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CTRL_REGS      = 8,
  parameter int NUM_STAT_REGS      = 4
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_CTRL_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_CTRL_REGS-1:0]                 ctrl_wr_pulse,
`ifdef TRIG_FMT_REGS_LOCK_EN
  input  logic                                     cfg_lock,
`endif
  input  logic [((NUM_STAT_REGS > 0) ? NUM_STAT_REGS : 1)*C_S_AXI_DATA_WIDTH-1:0] stat_in
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SW    = DW / 8;
  localparam int LSB   = $clog2(SW);
  localparam int IDX_W = AW - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (DW != 32 && DW != 64) begin : g_bad_dw
    $error("C_S_AXI_DATA_WIDTH must be 32 or 64");
  end
  if (NUM_CTRL_REGS < 1) begin : g_bad_nctrl
    $error("NUM_CTRL_REGS must be at least 1");
  end
  if (NUM_CTRL_REGS + NUM_STAT_REGS > (1 << IDX_W)) begin : g_bad_map
    $error("register count exceeds the address space");
  end

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // ---------------- write path ----------------
  w_state_t               w_state_reg, w_state_next;
  logic                   aw_ready_reg, aw_ready_next, w_ready_reg, w_ready_next;
  logic                   aw_held_reg, aw_held_next, w_held_reg, w_held_next;
  logic [IDX_W-1:0]       wr_idx_reg, wr_idx_next;
  logic [DW-1:0]          wr_data_reg, wr_data_next;
  logic [SW-1:0]          wr_strb_reg, wr_strb_next;
  logic                   b_valid_reg, b_valid_next;
  logic [1:0]             b_resp_reg, b_resp_next;
  logic [NUM_CTRL_REGS-1:0] wr_pulse_reg, wr_pulse_next;
  logic                   commit, wr_accept;
  logic [DW-1:0]          ctrl_reg [NUM_CTRL_REGS];

`ifdef TRIG_FMT_REGS_LOCK_EN
  assign wr_accept = (32'(wr_idx_reg) < NUM_CTRL_REGS) && !cfg_lock;
`else
  assign wr_accept = (32'(wr_idx_reg) < NUM_CTRL_REGS);
`endif

  always_comb begin
    w_state_next  = w_state_reg;
    aw_ready_next = 1'b0;
    w_ready_next  = 1'b0;
    aw_held_next  = aw_held_reg;
    w_held_next   = w_held_reg;
    wr_idx_next   = wr_idx_reg;
    wr_data_next  = wr_data_reg;
    wr_strb_next  = wr_strb_reg;
    b_valid_next  = b_valid_reg;
    b_resp_next   = b_resp_reg;
    wr_pulse_next = '0;
    commit        = 1'b0;
    unique case (w_state_reg)
      W_IDLE: begin
        if (aw_held_reg && w_held_reg) begin
          commit       = 1'b1;
          w_state_next = W_RESP;
          aw_held_next = 1'b0;
          w_held_next  = 1'b0;
          b_valid_next = 1'b1;
          b_resp_next  = wr_accept ? RESP_OKAY : RESP_SLVERR;
          for (int i = 0; i < NUM_CTRL_REGS; i++)
            wr_pulse_next[i] = wr_accept && (32'(wr_idx_reg) == i);
        end else begin
          if (aw_ready_reg && S_AXI_AWVALID) begin
            aw_held_next = 1'b1;
            wr_idx_next  = S_AXI_AWADDR[AW-1:LSB];
          end
          if (w_ready_reg && S_AXI_WVALID) begin
            w_held_next  = 1'b1;
            wr_data_next = S_AXI_WDATA;
            wr_strb_next = S_AXI_WSTRB;
          end
          aw_ready_next = !aw_held_next;
          w_ready_next  = !w_held_next;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_next  = W_IDLE;
          b_valid_next  = 1'b0;
          b_resp_next   = RESP_OKAY;
          aw_ready_next = 1'b1;
          w_ready_next  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_reg  <= W_IDLE;
      aw_ready_reg <= 1'b0;
      w_ready_reg  <= 1'b0;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      wr_idx_reg   <= '0;
      wr_data_reg  <= '0;
      wr_strb_reg  <= '0;
      b_valid_reg  <= 1'b0;
      b_resp_reg   <= RESP_OKAY;
      wr_pulse_reg <= '0;
    end else begin
      w_state_reg  <= w_state_next;
      aw_ready_reg <= aw_ready_next;
      w_ready_reg  <= w_ready_next;
      aw_held_reg  <= aw_held_next;
      w_held_reg   <= w_held_next;
      wr_idx_reg   <= wr_idx_next;
      wr_data_reg  <= wr_data_next;
      wr_strb_reg  <= wr_strb_next;
      b_valid_reg  <= b_valid_next;
      b_resp_reg   <= b_resp_next;
      wr_pulse_reg <= wr_pulse_next;
    end
  end

  // Lanes whose strobe is clear keep their previous contents.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_CTRL_REGS; i++) ctrl_reg[i] <= '0;
    end else if (commit && wr_accept) begin
      for (int i = 0; i < NUM_CTRL_REGS; i++)
        for (int b = 0; b < SW; b++)
          if ((32'(wr_idx_reg) == i) && wr_strb_reg[b])
            ctrl_reg[i][8*b +: 8] <= wr_data_reg[8*b +: 8];
    end
  end

  // ---------------- read path ----------------
  r_state_t         r_state_reg, r_state_next;
  logic             ar_ready_reg, ar_ready_next;
  logic             r_valid_reg, r_valid_next;
  logic [DW-1:0]    r_data_reg, r_data_next;
  logic [1:0]       r_resp_reg, r_resp_next;
  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0]    rd_mux;
  logic             rd_hit;

  assign rd_idx = S_AXI_ARADDR[AW-1:LSB];

  always_comb begin
    rd_mux = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_CTRL_REGS; i++)
      if (32'(rd_idx) == i) begin
        rd_mux = ctrl_reg[i];
        rd_hit = 1'b1;
      end
    for (int i = 0; i < NUM_STAT_REGS; i++)
      if (32'(rd_idx) == NUM_CTRL_REGS + i) begin
        rd_mux = stat_in[i*DW +: DW];
        rd_hit = 1'b1;
      end
  end

  always_comb begin
    r_state_next  = r_state_reg;
    ar_ready_next = 1'b0;
    r_valid_next  = r_valid_reg;
    r_data_next   = r_data_reg;
    r_resp_next   = r_resp_reg;
    unique case (r_state_reg)
      R_IDLE: begin
        if (ar_ready_reg && S_AXI_ARVALID) begin
          r_state_next = R_DATA;
          r_valid_next = 1'b1;
          r_data_next  = rd_mux;
          r_resp_next  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else begin
          ar_ready_next = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_state_next  = R_IDLE;
          r_valid_next  = 1'b0;
          ar_ready_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state_reg  <= R_IDLE;
      ar_ready_reg <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= '0;
      r_resp_reg   <= RESP_OKAY;
    end else begin
      r_state_reg  <= r_state_next;
      ar_ready_reg <= ar_ready_next;
      r_valid_reg  <= r_valid_next;
      r_data_reg   <= r_data_next;
      r_resp_reg   <= r_resp_next;
    end
  end

  // ---------------- outputs ----------------
  for (genvar gi = 0; gi < NUM_CTRL_REGS; gi++) begin : g_flat
    assign ctrl_regs[gi*DW +: DW] = ctrl_reg[gi];
  end

  assign S_AXI_AWREADY = aw_ready_reg;
  assign S_AXI_WREADY  = w_ready_reg;
  assign S_AXI_BVALID  = b_valid_reg;
  assign S_AXI_BRESP   = b_resp_reg;
  assign S_AXI_ARREADY = ar_ready_reg;
  assign S_AXI_RVALID  = r_valid_reg;
  assign S_AXI_RDATA   = r_data_reg;
  assign S_AXI_RRESP   = r_resp_reg;
  assign ctrl_wr_pulse = wr_pulse_reg;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

endmodule
